// File: rtl/detect_capture_fifo.sv
// detect_capture_fifo: captures detector strobes into a FIFO drained over an AXI-lite slave
// Ports: clk, res_n (async active-low), sig/data capture input, s_axi_* AXI-lite slave,
//        full/ovf registered status. Optional DETECT_CAPTURE_TSTAMP_EN adds per-entry timestamps.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef RESP_OKAY
`define RESP_OKAY 2'b00
`endif
module detect_capture_fifo #(
  parameter int DEPTH        = 16,
  parameter bit EDGE_CAPTURE = 1'b0
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic                       sig,
  input  logic [`AXI_DATA_WIDTH-1:0] data,
  input  logic [31:0]                s_axi_araddr_i,
  input  logic                       s_axi_arvalid_i,
  output logic                       s_axi_arready_o,
  output logic [`AXI_DATA_WIDTH-1:0] s_axi_rdata_o,
  output logic [1:0]                 s_axi_rresp_o,
  output logic                       s_axi_rvalid_o,
  input  logic                       s_axi_rready_i,
  input  logic [31:0]                s_axi_awaddr_i,
  input  logic                       s_axi_awvalid_i,
  output logic                       s_axi_awready_o,
  input  logic [`AXI_DATA_WIDTH-1:0] s_axi_wdata_i,
  input  logic                       s_axi_wvalid_i,
  output logic                       s_axi_wready_o,
  output logic [1:0]                 s_axi_bresp_o,
  output logic                       s_axi_bvalid_o,
  input  logic                       s_axi_bready_i,
  output logic                       full,
  output logic                       ovf
);
  localparam int DW = `AXI_DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  r_state_t rs_q;
  w_state_t ws_q;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d, wdata_q, wdata_d, ts_rd;
  logic [1:0] awaddr_q, waddr, raddr;
  logic sig_q, ovf_q, ovf_d, full_q, arready_q, rvalid_q, awready_q, wready_q, bvalid_q, aw_q, w_q;
  logic ar_hs, aw_hs, w_hs, aw_d, w_d, wr_en, push, pop, accept, drop, flush, clr, empty;
  logic unused_ok;
  assign raddr   = s_axi_araddr_i[3:2];
  assign ar_hs   = rs_q == R_IDLE && s_axi_arvalid_i && arready_q;
  assign aw_hs   = ws_q == W_IDLE && s_axi_awvalid_i && awready_q;
  assign w_hs    = ws_q == W_IDLE && s_axi_wvalid_i && wready_q;
  assign aw_d    = aw_q || aw_hs;
  assign w_d     = w_q || w_hs;
  // the write takes effect in the cycle the second of AW/W is latched
  assign wr_en   = ws_q == W_IDLE && aw_d && w_d;
  assign waddr   = aw_hs ? s_axi_awaddr_i[3:2] : awaddr_q;
  assign wdata_d = w_hs ? s_axi_wdata_i : wdata_q;
  assign flush   = wr_en && waddr == 2'd1 && wdata_d[31];
  assign clr     = wr_en && waddr == 2'd1 && wdata_d[18];
  assign empty   = cnt_q == '0;
  assign push    = sig && (!EDGE_CAPTURE || !sig_q);
  assign pop     = ar_hs && raddr == 2'd0 && !empty;
  assign accept  = push && (!full_q || pop);
  assign drop    = push && full_q && !pop;
  // flush suppresses the overflow of a concurrent push; a new overflow beats a clear
  assign ovf_d   = (drop && !flush) || (ovf_q && !clr);
  assign cnt_d   = flush ? '0 : cnt_q + CW'(accept) - CW'(pop);
  assign rdata_d = raddr == 2'd0 ? (empty ? '0 : mem[rp_q]) :
                   raddr == 2'd1 ? DW'({13'b0, ovf_q, full_q, empty, 16'(cnt_q)}) :
                   raddr == 2'd2 ? ts_rd : '0;
  assign s_axi_arready_o = arready_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = `RESP_OKAY;
  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = `RESP_OKAY;
  assign full            = full_q;
  assign ovf             = ovf_q;
  assign unused_ok = ^{s_axi_araddr_i[31:4], s_axi_araddr_i[1:0], s_axi_awaddr_i[31:4],
                       s_axi_awaddr_i[1:0], wdata_d[30:19], wdata_d[17:0]};
  always_ff @(posedge clk) if (accept) mem[wp_q] <= data;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      sig_q  <= 1'b0;
      ovf_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      wp_q   <= flush ? '0 : wp_q + AW'(accept);
      rp_q   <= flush ? '0 : rp_q + AW'(pop);
      cnt_q  <= cnt_d;
      sig_q  <= sig;
      ovf_q  <= ovf_d;
      full_q <= cnt_d == CW'(DEPTH);
    end
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rs_q      <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else if (rs_q == R_IDLE) begin
      arready_q <= !ar_hs;
      if (ar_hs) begin
        rdata_q  <= rdata_d;
        rvalid_q <= 1'b1;
        rs_q     <= R_RESP;
      end
    end else if (s_axi_rready_i) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
      rs_q      <= R_IDLE;
    end
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ws_q      <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_q      <= 1'b0;
      w_q       <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else if (ws_q == W_IDLE) begin
      if (aw_hs) awaddr_q <= s_axi_awaddr_i[3:2];
      if (w_hs) wdata_q <= s_axi_wdata_i;
      aw_q      <= aw_d && !wr_en;
      w_q       <= w_d && !wr_en;
      awready_q <= !aw_d;
      wready_q  <= !w_d;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        ws_q     <= W_RESP;
      end
    end else if (s_axi_bready_i) begin
      bvalid_q  <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      ws_q      <= W_IDLE;
    end
  end
`ifdef DETECT_CAPTURE_TSTAMP_EN
  logic [31:0] tmem [DEPTH];
  logic [31:0] tcnt_q, ts_q;
  always_ff @(posedge clk) if (accept) tmem[wp_q] <= tcnt_q;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tcnt_q <= '0;
      ts_q   <= '0;
    end else begin
      tcnt_q <= tcnt_q + 32'd1;
      if (pop) ts_q <= tmem[rp_q];
    end
  end
  assign ts_rd = DW'(ts_q);
`else
  assign ts_rd = '0;
`endif
endmodule
